// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: shared definitions for the command frame controller.
//   - frame opcodes (first byte of every frame)
//   - RegFile addresses that receive the ALU operands A and B
//   - FSM state encoding
package cmd_frame_pkg;

  localparam logic [7:0] OpRfWrite       = 8'hAA;  // op, addr, data
  localparam logic [7:0] OpRfRead        = 8'hBB;  // op, addr
  localparam logic [7:0] OpAluOperands   = 8'hCC;  // op, A, B, func
  localparam logic [7:0] OpAluNoOperands = 8'hDD;  // op, func

  localparam int unsigned AluOpAAddr = 0;
  localparam int unsigned AluOpBAddr = 1;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StOpA,
    StOpB,
    StFunc,
    StAluWait,
    StTx
  } state_e;

endpackage

// File: rtl/resp_serializer.sv
// resp_serializer: holds a multi-byte result and emits it into the TX FIFO, LSB byte first.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          capture i_data / i_len (only issued while idle)
//   i_len           number of bytes to emit
//   i_data          result word, byte 0 in the LSBs
//   i_fifo_full     FIFO full flag; no write while high
//   o_tx_data       byte currently pending (held while the FIFO is full)
//   o_fifo_wr       FIFO write strobe
//   o_done          high in the cycle the last byte is written
module resp_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RES_BYTES  = 2,
  parameter int unsigned LEN_WIDTH  = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_load,
  input  logic [LEN_WIDTH-1:0]            i_len,
  input  logic [RES_BYTES*DATA_WIDTH-1:0] i_data,
  input  logic                            i_fifo_full,
  output logic [DATA_WIDTH-1:0]           o_tx_data,
  output logic                            o_fifo_wr,
  output logic                            o_done
);

  logic [RES_BYTES*DATA_WIDTH-1:0] r_result;
  logic [LEN_WIDTH-1:0]            r_remaining;
  logic                            w_busy;
  logic                            w_push;

  assign w_busy = (r_remaining != '0);
  // The pending byte is registered; the strobe is gated by the live full flag so a byte is
  // never written into a full FIFO and is retried on the first non-full cycle.
  assign w_push = w_busy & ~i_fifo_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result    <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_result    <= i_data;
      r_remaining <= i_len;
    end else if (w_push) begin
      r_result    <= r_result >> DATA_WIDTH;
      r_remaining <= r_remaining - LEN_WIDTH'(1);
    end
  end

  assign o_tx_data = r_result[DATA_WIDTH-1:0];
  assign o_fifo_wr = w_push;
  assign o_done    = w_push && (r_remaining == LEN_WIDTH'(1));

endmodule

// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl: parses byte-framed commands from the UART RX path, drives RegFile writes and
// reads and ALU operations, and returns results as bytes into the TX FIFO.
// Optional feature: define CMD_TIMEOUT_EN to abort a partially received frame after
// TIMEOUT_CYCLES idle cycles (CMD_ERR pulse, back to idle).
// Ports:
//   CLK, RST                    clock, asynchronous active-low reset
//   RX_DATA_IN/RX_DATA_VALID    received byte and its one-cycle valid pulse
//   RegFile_*                   address, write/read strobes, write data, read data + valid
//   ALU_FUNC/ALU_EN/ALU_CLK_EN  ALU function, enable and clock-gate enable
//   ALU_OUT/ALU_OUT_VALID       ALU result and its valid
//   TX_DATA_OUT/FIFO_WR         byte and write strobe towards the TX FIFO
//   FIFO_FULL                   TX FIFO full flag
//   CMD_ERR                     one-cycle pulse per rejected byte or timeout
module cmd_frame_ctrl
  import cmd_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned ALU_FUNC_WIDTH = 4,
  parameter int unsigned RES_BYTES      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           RX_DATA_IN,
  input  logic                            RX_DATA_VALID,
  output logic [ADDR_WIDTH-1:0]           RegFile_ADDRESS,
  output logic                            RegFile_WrEn,
  output logic                            RegFile_RdEn,
  output logic [DATA_WIDTH-1:0]           RegFile_WrData,
  input  logic [DATA_WIDTH-1:0]           RegFile_RdData,
  input  logic                            RegFile_RdData_Valid,
  output logic [ALU_FUNC_WIDTH-1:0]       ALU_FUNC,
  output logic                            ALU_EN,
  output logic                            ALU_CLK_EN,
  input  logic [RES_BYTES*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                            ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]           TX_DATA_OUT,
  output logic                            FIFO_WR,
  input  logic                            FIFO_FULL,
  output logic                            CMD_ERR
);

  localparam int unsigned LenW = $clog2(RES_BYTES + 1);

  state_e                          r_state, w_state_d;
  logic [ADDR_WIDTH-1:0]           r_addr, w_addr_d;
  logic [DATA_WIDTH-1:0]           r_wr_data, w_wr_data_d;
  logic [ALU_FUNC_WIDTH-1:0]       r_func, w_func_d;
  logic                            r_wr_en, w_wr_en_d;
  logic                            r_rd_en, w_rd_en_d;
  logic                            r_alu_active;
  logic                            r_err, w_err_d;
  logic                            w_take_op;
  logic                            w_load;
  logic [LenW-1:0]                 w_load_len;
  logic [RES_BYTES*DATA_WIDTH-1:0] w_load_data;
  logic                            w_done;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] r_tmo_cnt, w_tmo_cnt_d;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_wr_data_d = r_wr_data;
    w_func_d    = r_func;
    w_wr_en_d   = 1'b0;
    w_rd_en_d   = 1'b0;
    w_err_d     = 1'b0;
    w_take_op   = 1'b0;
    w_load      = 1'b0;
    w_load_len  = '0;
    w_load_data = '0;

    unique case (r_state)
      StIdle: w_take_op = RX_DATA_VALID;
      StWrAddr: begin
        if (RX_DATA_VALID) begin
          w_addr_d  = RX_DATA_IN[ADDR_WIDTH-1:0];
          w_state_d = StWrData;
        end
      end
      StWrData: begin
        if (RX_DATA_VALID) begin
          w_wr_data_d = RX_DATA_IN;
          w_wr_en_d   = 1'b1;
          w_state_d   = StIdle;
        end
      end
      StRdAddr: begin
        if (RX_DATA_VALID) begin
          w_addr_d  = RX_DATA_IN[ADDR_WIDTH-1:0];
          w_rd_en_d = 1'b1;
          w_state_d = StRdWait;
        end
      end
      StRdWait: begin
        w_err_d = RX_DATA_VALID;
        if (RegFile_RdData_Valid) begin
          w_load                      = 1'b1;
          w_load_len                  = LenW'(1);
          w_load_data[DATA_WIDTH-1:0] = RegFile_RdData;
          w_state_d                   = StTx;
        end
      end
      StOpA: begin
        if (RX_DATA_VALID) begin
          w_addr_d    = ADDR_WIDTH'(AluOpAAddr);
          w_wr_data_d = RX_DATA_IN;
          w_wr_en_d   = 1'b1;
          w_state_d   = StOpB;
        end
      end
      StOpB: begin
        if (RX_DATA_VALID) begin
          w_addr_d    = ADDR_WIDTH'(AluOpBAddr);
          w_wr_data_d = RX_DATA_IN;
          w_wr_en_d   = 1'b1;
          w_state_d   = StFunc;
        end
      end
      StFunc: begin
        if (RX_DATA_VALID) begin
          w_func_d  = RX_DATA_IN[ALU_FUNC_WIDTH-1:0];
          w_state_d = StAluWait;
        end
      end
      StAluWait: begin
        w_err_d = RX_DATA_VALID;
        if (ALU_OUT_VALID) begin
          w_load      = 1'b1;
          w_load_len  = LenW'(RES_BYTES);
          w_load_data = ALU_OUT;
          w_state_d   = StTx;
        end
      end
      StTx: begin
        if (w_done) begin
          // A byte coinciding with the last FIFO write opens the next frame.
          w_state_d = StIdle;
          w_take_op = RX_DATA_VALID;
        end else begin
          w_err_d = RX_DATA_VALID;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_take_op) begin
      if (RX_DATA_IN == DATA_WIDTH'(OpRfWrite)) begin
        w_state_d = StWrAddr;
      end else if (RX_DATA_IN == DATA_WIDTH'(OpRfRead)) begin
        w_state_d = StRdAddr;
      end else if (RX_DATA_IN == DATA_WIDTH'(OpAluOperands)) begin
        w_state_d = StOpA;
      end else if (RX_DATA_IN == DATA_WIDTH'(OpAluNoOperands)) begin
        w_state_d = StFunc;
      end else begin
        w_err_d = 1'b1;
      end
    end

`ifdef CMD_TIMEOUT_EN
    // Counts idle cycles only while a frame is partially received; any byte restarts it.
    w_tmo_cnt_d = '0;
    if ((r_state inside {StWrAddr, StWrData, StRdAddr, StOpA, StOpB, StFunc}) &&
        !RX_DATA_VALID) begin
      if (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1)) begin
        w_state_d = StIdle;
        w_err_d   = 1'b1;
      end else begin
        w_tmo_cnt_d = r_tmo_cnt + TmoW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_func       <= '0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_alu_active <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_addr       <= w_addr_d;
      r_wr_data    <= w_wr_data_d;
      r_func       <= w_func_d;
      r_wr_en      <= w_wr_en_d;
      r_rd_en      <= w_rd_en_d;
      r_alu_active <= (w_state_d == StAluWait);
      r_err        <= w_err_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_d;
    end
  end
`endif

  resp_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .RES_BYTES (RES_BYTES),
    .LEN_WIDTH (LenW)
  ) u_resp_serializer (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_load     (w_load),
    .i_len      (w_load_len),
    .i_data     (w_load_data),
    .i_fifo_full(FIFO_FULL),
    .o_tx_data  (TX_DATA_OUT),
    .o_fifo_wr  (FIFO_WR),
    .o_done     (w_done)
  );

  assign RegFile_ADDRESS = r_addr;
  assign RegFile_WrEn    = r_wr_en;
  assign RegFile_RdEn    = r_rd_en;
  assign RegFile_WrData  = r_wr_data;
  assign ALU_FUNC        = r_func;
  assign ALU_EN          = r_alu_active;
  assign ALU_CLK_EN      = r_alu_active;
  assign CMD_ERR         = r_err;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// tb_cmd_frame_ctrl: directed self-checking bench for cmd_frame_ctrl with a small RegFile model.
module tb_cmd_frame_ctrl;
  import cmd_frame_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_DATA_IN = 8'h00;
  logic        RX_DATA_VALID = 1'b0;
  logic [3:0]  RegFile_ADDRESS;
  logic        RegFile_WrEn;
  logic        RegFile_RdEn;
  logic [7:0]  RegFile_WrData;
  logic [7:0]  rf_rdata;
  logic        rf_valid;
  logic [3:0]  ALU_FUNC;
  logic        ALU_EN;
  logic        ALU_CLK_EN;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        ALU_OUT_VALID = 1'b0;
  logic [7:0]  TX_DATA_OUT;
  logic        FIFO_WR;
  logic        FIFO_FULL = 1'b0;
  logic        CMD_ERR;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [11:0] wr_q[$];
  int          err_cnt   = 0;
  int          rd_cnt    = 0;
  int          full_viol = 0;
  logic [7:0]  mem [16];

  always #5 CLK = ~CLK;

  cmd_frame_ctrl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .RX_DATA_IN          (RX_DATA_IN),
    .RX_DATA_VALID       (RX_DATA_VALID),
    .RegFile_ADDRESS     (RegFile_ADDRESS),
    .RegFile_WrEn        (RegFile_WrEn),
    .RegFile_RdEn        (RegFile_RdEn),
    .RegFile_WrData      (RegFile_WrData),
    .RegFile_RdData      (rf_rdata),
    .RegFile_RdData_Valid(rf_valid),
    .ALU_FUNC            (ALU_FUNC),
    .ALU_EN              (ALU_EN),
    .ALU_CLK_EN          (ALU_CLK_EN),
    .ALU_OUT             (ALU_OUT),
    .ALU_OUT_VALID       (ALU_OUT_VALID),
    .TX_DATA_OUT         (TX_DATA_OUT),
    .FIFO_WR             (FIFO_WR),
    .FIFO_FULL           (FIFO_FULL),
    .CMD_ERR             (CMD_ERR)
  );

  // RegFile model: registered read, valid one cycle after RdEn.
  always @(posedge CLK) begin
    rf_valid <= RegFile_RdEn;
    rf_rdata <= mem[RegFile_ADDRESS];
    if (RegFile_WrEn) mem[RegFile_ADDRESS] <= RegFile_WrData;
  end

  // Activity log sampled mid-cycle.
  always @(negedge CLK) begin
    if (FIFO_WR) tx_q.push_back(TX_DATA_OUT);
    if (FIFO_WR && FIFO_FULL) full_viol <= full_viol + 1;
    if (RegFile_WrEn) wr_q.push_back({RegFile_ADDRESS, RegFile_WrData});
    if (RegFile_RdEn) rd_cnt <= rd_cnt + 1;
    if (CMD_ERR) err_cnt <= err_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA_IN    = b;
    RX_DATA_VALID = 1'b1;
    cyc(1);
    RX_DATA_VALID = 1'b0;
  endtask

  task automatic alu_respond(input logic [15:0] v);
    ALU_OUT       = v;
    ALU_OUT_VALID = 1'b1;
    cyc(1);
    ALU_OUT_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    cyc(2);
    checks++;
    if ({RegFile_ADDRESS, RegFile_WrEn, RegFile_RdEn, RegFile_WrData, ALU_FUNC, ALU_EN,
         ALU_CLK_EN, TX_DATA_OUT, FIFO_WR, CMD_ERR} !== 33'h0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    checks++;
    if (dut.r_state !== StIdle) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, StIdle);
    end
    RST = 1'b1;
    cyc(1);
  endtask

  task automatic test_rf_write_read();
    int n0 = tx_q.size();
    int r0 = rd_cnt;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    checks++;
    if ({RegFile_WrEn, RegFile_ADDRESS, RegFile_WrData} !== {1'b1, 4'h5, 8'h3C}) begin
      errors++; $display("FAIL rf_write: got en=%b a=%h d=%h want 1 5 3c",
                         RegFile_WrEn, RegFile_ADDRESS, RegFile_WrData);
    end
    cyc(1);
    checks++;
    if (RegFile_WrEn !== 1'b0) begin
      errors++; $display("FAIL rf_write_pulse: got %b want 0", RegFile_WrEn);
    end
    send_byte(8'hBB); send_byte(8'h05);
    checks++;
    if ({RegFile_RdEn, RegFile_ADDRESS} !== {1'b1, 4'h5}) begin
      errors++; $display("FAIL rf_read_en: got en=%b a=%h want 1 5", RegFile_RdEn,
                         RegFile_ADDRESS);
    end
    cyc(1);
    checks++;
    if (RegFile_RdEn !== 1'b0 || dut.r_state !== StRdWait) begin
      errors++; $display("FAIL rf_read_wait: got en=%b st=%0d want 0 %0d", RegFile_RdEn,
                         dut.r_state, StRdWait);
    end
    cyc(1);
    checks++;
    if ({FIFO_WR, TX_DATA_OUT} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL rf_read_tx: got wr=%b d=%h want 1 3c", FIFO_WR, TX_DATA_OUT);
    end
    cyc(3);
    checks++;
    if (tx_q.size() != n0 + 1 || rd_cnt != r0 + 1) begin
      errors++; $display("FAIL rf_read_count: got tx=%0d rd=%0d want 1 1", tx_q.size() - n0,
                         rd_cnt - r0);
    end else begin
      checks++;
      if (tx_q[n0] !== 8'h3C) begin
        errors++; $display("FAIL rf_read_byte: got %h want 3c", tx_q[n0]);
      end
    end
  endtask

  task automatic test_alu_operands();
    int n0 = tx_q.size();
    int w0 = wr_q.size();
    send_byte(8'hCC); send_byte(8'h07);
    checks++;
    if ({RegFile_WrEn, RegFile_ADDRESS, RegFile_WrData} !== {1'b1, 4'h0, 8'h07}) begin
      errors++; $display("FAIL alu_op_a: got en=%b a=%h d=%h want 1 0 07", RegFile_WrEn,
                         RegFile_ADDRESS, RegFile_WrData);
    end
    send_byte(8'h03);
    checks++;
    if ({RegFile_WrEn, RegFile_ADDRESS, RegFile_WrData} !== {1'b1, 4'h1, 8'h03}) begin
      errors++; $display("FAIL alu_op_b: got en=%b a=%h d=%h want 1 1 03", RegFile_WrEn,
                         RegFile_ADDRESS, RegFile_WrData);
    end
    send_byte(8'h00);
    checks++;
    if ({ALU_EN, ALU_CLK_EN, ALU_FUNC} !== {2'b11, 4'h0}) begin
      errors++; $display("FAIL alu_start: got en=%b ce=%b f=%h want 1 1 0", ALU_EN, ALU_CLK_EN,
                         ALU_FUNC);
    end
    cyc(2);
    checks++;
    if ({ALU_EN, ALU_CLK_EN} !== 2'b11) begin
      errors++; $display("FAIL alu_hold: got en=%b ce=%b want 1 1", ALU_EN, ALU_CLK_EN);
    end
    alu_respond(16'h000A);
    checks++;
    if ({ALU_EN, ALU_CLK_EN, FIFO_WR, TX_DATA_OUT} !== {3'b001, 8'h0A}) begin
      errors++; $display("FAIL alu_capture: got en=%b ce=%b wr=%b d=%h want 0 0 1 0a", ALU_EN,
                         ALU_CLK_EN, FIFO_WR, TX_DATA_OUT);
    end
    cyc(4);
    checks++;
    if (tx_q.size() != n0 + 2 || wr_q.size() != w0 + 2) begin
      errors++; $display("FAIL alu_counts: got tx=%0d wr=%0d want 2 2", tx_q.size() - n0,
                         wr_q.size() - w0);
    end else begin
      checks++;
      if ({tx_q[n0], tx_q[n0+1], wr_q[w0], wr_q[w0+1]} !== {8'h0A, 8'h00, 12'h007, 12'h103})
      begin
        errors++; $display("FAIL alu_bytes: got %h %h %h %h want 0a 00 007 103", tx_q[n0],
                           tx_q[n0+1], wr_q[w0], wr_q[w0+1]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int n0 = tx_q.size();
    int v0 = full_viol;
    send_byte(8'hDD); send_byte(8'h02);
    checks++;
    if (ALU_FUNC !== 4'h2 || dut.r_state !== StAluWait) begin
      errors++; $display("FAIL func_latch: got f=%h st=%0d want 2 %0d", ALU_FUNC, dut.r_state,
                         StAluWait);
    end
    FIFO_FULL = 1'b1;
    alu_respond(16'h5AC3);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({FIFO_WR, TX_DATA_OUT} !== {1'b0, 8'hC3}) begin
        errors++; $display("FAIL full_hold%0d: got wr=%b d=%h want 0 c3", i, FIFO_WR,
                           TX_DATA_OUT);
      end
      cyc(1);
    end
    FIFO_FULL = 1'b0;
    cyc(1);
    FIFO_FULL = 1'b1;
    cyc(2);
    checks++;
    if ({FIFO_WR, TX_DATA_OUT} !== {1'b0, 8'h5A}) begin
      errors++; $display("FAIL full_mid: got wr=%b d=%h want 0 5a", FIFO_WR, TX_DATA_OUT);
    end
    FIFO_FULL = 1'b0;
    cyc(3);
    checks++;
    if (tx_q.size() != n0 + 2 || full_viol != v0 || dut.r_state !== StIdle) begin
      errors++; $display("FAIL full_counts: got tx=%0d viol=%0d st=%0d want 2 0 %0d",
                         tx_q.size() - n0, full_viol - v0, dut.r_state, StIdle);
    end else begin
      checks++;
      if ({tx_q[n0], tx_q[n0+1]} !== {8'hC3, 8'h5A}) begin
        errors++; $display("FAIL full_bytes: got %h %h want c3 5a", tx_q[n0], tx_q[n0+1]);
      end
    end
  endtask

  task automatic test_errors();
    int n0 = tx_q.size();
    int w0 = wr_q.size();
    int e0 = err_cnt;
    send_byte(8'h55);
    checks++;
    if (CMD_ERR !== 1'b1 || dut.r_state !== StIdle) begin
      errors++; $display("FAIL err_idle: got err=%b st=%0d want 1 %0d", CMD_ERR, dut.r_state,
                         StIdle);
    end
    cyc(1);
    checks++;
    if (CMD_ERR !== 1'b0) begin
      errors++; $display("FAIL err_idle_width: got %b want 0", CMD_ERR);
    end
    send_byte(8'hDD); send_byte(8'h01);
    cyc(1);
    send_byte(8'h77);
    checks++;
    if (CMD_ERR !== 1'b1 || dut.r_state !== StAluWait) begin
      errors++; $display("FAIL err_wait: got err=%b st=%0d want 1 %0d", CMD_ERR, dut.r_state,
                         StAluWait);
    end
    cyc(1);
    checks++;
    if (CMD_ERR !== 1'b0 || tx_q.size() != n0) begin
      errors++; $display("FAIL err_wait_quiet: got err=%b tx=%0d want 0 0", CMD_ERR,
                         tx_q.size() - n0);
    end
    alu_respond(16'h1234);
    cyc(4);
    checks++;
    if (err_cnt != e0 + 2 || wr_q.size() != w0 || tx_q.size() != n0 + 2) begin
      errors++; $display("FAIL err_counts: got err=%0d wr=%0d tx=%0d want 2 0 2", err_cnt - e0,
                         wr_q.size() - w0, tx_q.size() - n0);
    end else begin
      checks++;
      if ({tx_q[n0], tx_q[n0+1]} !== {8'h34, 8'h12}) begin
        errors++; $display("FAIL err_alu_bytes: got %h %h want 34 12", tx_q[n0], tx_q[n0+1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0 = tx_q.size();
    int e0 = err_cnt;
    send_byte(8'hDD); send_byte(8'h03);
    alu_respond(16'h0102);
    cyc(1);
    // Last byte is written this cycle; the new opcode arrives alongside it.
    send_byte(8'hAA);
    checks++;
    if (dut.r_state !== StWrAddr || CMD_ERR !== 1'b0) begin
      errors++; $display("FAIL b2b_opcode: got st=%0d err=%b want %0d 0", dut.r_state, CMD_ERR,
                         StWrAddr);
    end
    send_byte(8'h09); send_byte(8'h5E);
    checks++;
    if ({RegFile_WrEn, RegFile_ADDRESS, RegFile_WrData} !== {1'b1, 4'h9, 8'h5E}) begin
      errors++; $display("FAIL b2b_write: got en=%b a=%h d=%h want 1 9 5e", RegFile_WrEn,
                         RegFile_ADDRESS, RegFile_WrData);
    end
    cyc(2);
    checks++;
    if (tx_q.size() != n0 + 2 || err_cnt != e0) begin
      errors++; $display("FAIL b2b_counts: got tx=%0d err=%0d want 2 0", tx_q.size() - n0,
                         err_cnt - e0);
    end else begin
      checks++;
      if ({tx_q[n0], tx_q[n0+1]} !== {8'h02, 8'h01}) begin
        errors++; $display("FAIL b2b_bytes: got %h %h want 02 01", tx_q[n0], tx_q[n0+1]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n0;
    int w0;
    send_byte(8'hCC); send_byte(8'h11);
    cyc(1);
    RST = 1'b0;
    #1;
    checks++;
    if ({RegFile_ADDRESS, RegFile_WrEn, RegFile_RdEn, RegFile_WrData, ALU_FUNC, ALU_EN,
         ALU_CLK_EN, TX_DATA_OUT, FIFO_WR, CMD_ERR} !== 33'h0 || dut.r_state !== StIdle) begin
      errors++; $display("FAIL midreset: got st=%0d a=%h d=%h f=%h want idle, all 0",
                         dut.r_state, RegFile_ADDRESS, RegFile_WrData, ALU_FUNC);
    end
    cyc(2);
    RST = 1'b1;
    cyc(1);
    n0 = tx_q.size();
    w0 = wr_q.size();
    send_byte(8'hCC); send_byte(8'h04); send_byte(8'h05); send_byte(8'h01);
    checks++;
    if ({ALU_EN, ALU_FUNC} !== {1'b1, 4'h1}) begin
      errors++; $display("FAIL midreset_func: got en=%b f=%h want 1 1", ALU_EN, ALU_FUNC);
    end
    alu_respond(16'h0009);
    cyc(4);
    checks++;
    if (tx_q.size() != n0 + 2 || wr_q.size() != w0 + 2) begin
      errors++; $display("FAIL midreset_counts: got tx=%0d wr=%0d want 2 2", tx_q.size() - n0,
                         wr_q.size() - w0);
    end else begin
      checks++;
      if ({tx_q[n0], tx_q[n0+1], wr_q[w0], wr_q[w0+1]} !== {8'h09, 8'h00, 12'h004, 12'h105})
      begin
        errors++; $display("FAIL midreset_bytes: got %h %h %h %h want 09 00 004 105", tx_q[n0],
                           tx_q[n0+1], wr_q[w0], wr_q[w0+1]);
      end
    end
  endtask

  task automatic test_timeout();
    int e0;
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h66);
    cyc(1);
    e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h03);
`ifdef CMD_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (CMD_ERR !== 1'b0) begin
        errors++; $display("FAIL tmo_early%0d: got %b want 0", i, CMD_ERR);
      end
      cyc(1);
    end
    checks++;
    if (CMD_ERR !== 1'b1 || dut.r_state !== StIdle) begin
      errors++; $display("FAIL tmo_fire: got err=%b st=%0d want 1 %0d", CMD_ERR, dut.r_state,
                         StIdle);
    end
    cyc(1);
    send_byte(8'hBB); send_byte(8'h03);
    cyc(2);
    checks++;
    if ({FIFO_WR, TX_DATA_OUT} !== {1'b1, 8'h66} || err_cnt != e0 + 1) begin
      errors++; $display("FAIL tmo_recover: got wr=%b d=%h err=%0d want 1 66 1", FIFO_WR,
                         TX_DATA_OUT, err_cnt - e0);
    end
    cyc(2);
`else
    cyc(40);
    checks++;
    if (dut.r_state !== StWrData || err_cnt != e0) begin
      errors++; $display("FAIL no_tmo_wait: got st=%0d err=%0d want %0d 0", dut.r_state,
                         err_cnt - e0, StWrData);
    end
    send_byte(8'h77);
    checks++;
    if ({RegFile_WrEn, RegFile_ADDRESS, RegFile_WrData} !== {1'b1, 4'h3, 8'h77}) begin
      errors++; $display("FAIL no_tmo_write: got en=%b a=%h d=%h want 1 3 77", RegFile_WrEn,
                         RegFile_ADDRESS, RegFile_WrData);
    end
    cyc(2);
`endif
  endtask

  initial begin
    test_reset();
    test_rf_write_read();
    test_alu_operands();
    test_fifo_full();
    test_errors();
    test_back_to_back();
    test_reset_midframe();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
